// File: rtl/gray_rx_checker.sv
// Gray-coded stream monitor: decodes each sample to binary, checks single-bit transitions,
// tracks step direction, wrap-arounds, lock state and a saturating error count.
module gray_rx_checker #(
  parameter int DWID       = 8,
  parameter int ERR_CNT_W  = 16,
  parameter int WRAP_CNT_W = 16,
  parameter int LOCK_N     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_valid,
  input  logic [DWID-1:0]       i_gray,
  output logic                  o_valid,
  output logic [DWID-1:0]       o_bin,
  output logic                  o_step,
  output logic                  o_dir_up,
  output logic                  o_err,
  output logic                  o_locked,
  output logic [ERR_CNT_W-1:0]  o_err_cnt,
  output logic [WRAP_CNT_W-1:0] o_wrap_cnt
);

  localparam logic [DWID-1:0]      BIN_MAX  = {DWID{1'b1}};
  localparam logic [DWID-1:0]      BIN_ZERO = {DWID{1'b0}};
  localparam logic [DWID-1:0]      BIN_ONE  = {{(DWID-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [3:0]           LOCK_N_C = 4'(LOCK_N);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_LOCK   = 2'd1,
    ST_RESYNC = 2'd2
  } state_t;

  function automatic logic [DWID-1:0] gray2bin(input logic [DWID-1:0] g);
    logic [DWID-1:0] b;
    b[DWID-1] = g[DWID-1];
    for (int i = DWID - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic is_onehot(input logic [DWID-1:0] x);
    return (x != BIN_ZERO) && ((x & (x - BIN_ONE)) == BIN_ZERO);
  endfunction

  state_t          state_r, state_nx_s;
  logic [3:0]      good_r, good_nx_s;
  logic [DWID-1:0] prev_gray_r;
  logic [DWID-1:0] bin_new_s, bin_prev_s, diff_s;
  logic            eval_s, good_s, step_s, err_s, up_wrap_s, dn_wrap_s;

  assign bin_new_s  = gray2bin(i_gray);
  assign bin_prev_s = gray2bin(prev_gray_r);
  assign diff_s     = i_gray ^ prev_gray_r;

  // Classify the incoming sample against the stored reference.
  always_comb begin
    eval_s    = i_valid && (state_r != ST_ACQ);
    good_s    = (diff_s == BIN_ZERO) || is_onehot(diff_s);
    step_s    = eval_s && is_onehot(diff_s);
    err_s     = eval_s && !good_s;
    up_wrap_s = step_s && (bin_prev_s == BIN_MAX) && (bin_new_s == BIN_ZERO);
    dn_wrap_s = step_s && (bin_prev_s == BIN_ZERO) && (bin_new_s == BIN_MAX);
  end

  // Lock state machine register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACQ;
      good_r  <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      good_r  <= good_nx_s;
    end
  end

  // Next-state logic; the good-sample run only matters while resyncing.
  always_comb begin
    state_nx_s = state_r;
    good_nx_s  = good_r;
    case (state_r)
      ST_ACQ: begin
        if (i_valid) begin
          state_nx_s = ST_LOCK;
          good_nx_s  = 4'd0;
        end else begin
          state_nx_s = ST_ACQ;
        end
      end
      ST_LOCK: begin
        if (err_s) begin
          state_nx_s = ST_RESYNC;
          good_nx_s  = 4'd0;
        end else begin
          state_nx_s = ST_LOCK;
        end
      end
      ST_RESYNC: begin
        if (err_s) begin
          good_nx_s = 4'd0;
        end else if (i_valid) begin
          if ((good_r + 4'd1) >= LOCK_N_C) begin
            state_nx_s = ST_LOCK;
            good_nx_s  = 4'd0;
          end else begin
            good_nx_s = good_r + 4'd1;
          end
        end else begin
          good_nx_s = good_r;
        end
      end
      default: begin
        state_nx_s = ST_ACQ;
        good_nx_s  = 4'd0;
      end
    endcase
  end

  // Registered outputs, reference sample and counters; a clear overrides a same-cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_bin       <= BIN_ZERO;
      o_step      <= 1'b0;
      o_dir_up    <= 1'b0;
      o_err       <= 1'b0;
      o_locked    <= 1'b0;
      o_err_cnt   <= {ERR_CNT_W{1'b0}};
      o_wrap_cnt  <= {WRAP_CNT_W{1'b0}};
      prev_gray_r <= BIN_ZERO;
    end else begin
      o_valid  <= i_valid;
      o_step   <= step_s;
      o_err    <= err_s;
      o_locked <= (state_nx_s == ST_LOCK);
      if (i_valid) begin
        o_bin       <= bin_new_s;
        prev_gray_r <= i_gray;
      end
      if (step_s) begin
        o_dir_up <= ((bin_new_s - bin_prev_s) == BIN_ONE);
      end
      if (i_clr) begin
        o_err_cnt <= {ERR_CNT_W{1'b0}};
      end else if (err_s && (o_err_cnt != ERR_MAX)) begin
        o_err_cnt <= o_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      if (i_clr) begin
        o_wrap_cnt <= {WRAP_CNT_W{1'b0}};
      end else if (up_wrap_s) begin
        o_wrap_cnt <= o_wrap_cnt + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
      end else if (dn_wrap_s) begin
        o_wrap_cnt <= o_wrap_cnt - {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_gray_rx_checker.sv
// Self-checking bench for gray_rx_checker: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_gray_rx_checker;

  localparam int DW  = 8;
  localparam int EW  = 2;
  localparam int WW  = 16;
  localparam int LN  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_clr = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_gray = 8'h00;
  logic          o_valid, o_step, o_dir_up, o_err, o_locked;
  logic [DW-1:0] o_bin;
  logic [EW-1:0] o_err_cnt;
  logic [WW-1:0] o_wrap_cnt;

  gray_rx_checker #(.DWID(DW), .ERR_CNT_W(EW), .WRAP_CNT_W(WW), .LOCK_N(LN)) dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_valid(i_valid), .i_gray(i_gray),
    .o_valid(o_valid), .o_bin(o_bin), .o_step(o_step), .o_dir_up(o_dir_up),
    .o_err(o_err), .o_locked(o_locked), .o_err_cnt(o_err_cnt), .o_wrap_cnt(o_wrap_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit          m_acq = 1'b1;
  bit          m_locked = 1'b0;
  int          m_good = 0;
  int          m_prev = 0;
  int          m_bin = 0, m_valid = 0, m_step = 0, m_err = 0, m_dir = 0;
  int          m_errc = 0;
  int          m_wrap = 0;
  int          sweep_steps = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 0; i < DW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 255;
  endfunction

  task automatic model(input bit r, input bit c, input bit v, input int g);
    int d, nb, pb;
    if (r) begin
      m_acq = 1; m_locked = 0; m_good = 0; m_prev = 0;
      m_bin = 0; m_valid = 0; m_step = 0; m_err = 0; m_dir = 0; m_errc = 0; m_wrap = 0;
      return;
    end
    m_valid = v; m_step = 0; m_err = 0;
    if (v) begin
      nb = g2b(g);
      m_bin = nb;
      if (m_acq) begin
        m_acq = 0; m_locked = 1; m_good = 0;
      end else begin
        d  = $countones(g ^ m_prev);
        pb = g2b(m_prev);
        if (d <= 1) begin
          if (d == 1) begin
            m_step = 1;
            m_dir  = (((nb - pb) & 255) == 1) ? 1 : 0;
            if (pb == 255 && nb == 0) m_wrap = (m_wrap + 1) % 65536;
            if (pb == 0 && nb == 255) m_wrap = (m_wrap + 65535) % 65536;
          end
          if (!m_locked) begin
            m_good++;
            if (m_good >= LN) begin m_locked = 1; m_good = 0; end
          end
        end else begin
          m_err = 1;
          if (m_errc < (1 << EW) - 1) m_errc++;
          m_locked = 0; m_good = 0;
        end
      end
      m_prev = g;
    end
    if (c) begin m_errc = 0; m_wrap = 0; end
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input int g);
    rst = r; i_clr = c; i_valid = v; i_gray = g[7:0];
    @(posedge clk);
    model(r, c, v, g);
    #1;
    check("valid",  32'(o_valid),    32'(m_valid));
    check("bin",    32'(o_bin),      32'(m_bin));
    check("step",   32'(o_step),     32'(m_step));
    check("dir_up", 32'(o_dir_up),   32'(m_dir));
    check("err",    32'(o_err),      32'(m_err));
    check("locked", 32'(o_locked),   32'(m_locked));
    check("errcnt", 32'(o_err_cnt),  32'(m_errc));
    check("wrapcnt",32'(o_wrap_cnt), 32'(m_wrap));
  endtask

  initial begin
    int r, g;
    // Reset and acquire
    repeat (3) cyc(1, 0, 0, 0);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_bin", 32'(o_bin), 32'd0);
    cyc(0, 0, 1, 8'h0C);
    check("acq_bin", 32'(o_bin), 32'h08);
    check("acq_locked", 32'(o_locked), 32'd1);
    check("acq_err", 32'(o_err), 32'd0);

    // Up sweep from bin 0
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    sweep_steps = 0;
    for (int b = 1; b <= 256; b++) begin
      cyc(0, 0, 1, b2g(b & 255));
      sweep_steps += o_step;
    end
    check("up_steps", 32'(sweep_steps), 32'd256);
    check("up_dir", 32'(o_dir_up), 32'd1);
    check("up_wrap", 32'(o_wrap_cnt), 32'd1);
    check("up_errcnt", 32'(o_err_cnt), 32'd0);

    // Down sweep with holds
    cyc(0, 0, 1, b2g(255));
    check("dn_wrap", 32'(o_wrap_cnt), 32'd0);
    check("dn_dir", 32'(o_dir_up), 32'd0);
    repeat (3) begin
      cyc(0, 0, 1, b2g(255));
      check("hold_step", 32'(o_step), 32'd0);
    end
    cyc(0, 0, 1, b2g(254));
    check("dn_step", 32'(o_step), 32'd1);

    // Error and relock
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 1, 8'h03);
    check("e_err", 32'(o_err), 32'd1);
    check("e_locked", 32'(o_locked), 32'd0);
    check("e_cnt", 32'(o_err_cnt), 32'd1);
    check("e_bin", 32'(o_bin), 32'h02);
    cyc(0, 0, 1, 8'h01);
    check("r1_locked", 32'(o_locked), 32'd0);
    cyc(0, 0, 1, 8'h00);
    check("r2_locked", 32'(o_locked), 32'd1);

    // Saturation and clear on an error cycle
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, (k % 2 == 0) ? 8'h0F : 8'h00);
    check("sat_cnt", 32'(o_err_cnt), 32'd3);
    cyc(0, 1, 1, 8'h0F);
    check("clr_err", 32'(o_err), 32'd1);
    check("clr_cnt", 32'(o_err_cnt), 32'd0);

    // Reset mid-stream, then first sample is an acquire
    cyc(0, 0, 1, b2g(8'h40));
    cyc(1, 0, 0, 0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    cyc(0, 0, 1, 8'hFF);
    check("mid_acq_err", 32'(o_err), 32'd0);
    check("mid_acq_locked", 32'(o_locked), 32'd1);
    check("mid_acq_bin", 32'(o_bin), 32'hAA);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        cyc(1, 0, 0, 0);
      end else if (r < 16) begin
        cyc(0, $urandom_range(0, 29) == 0, 0, $urandom_range(0, 255));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40)      g = b2g((g2b(m_prev) + 1) & 255);
        else if (r < 65) g = b2g((g2b(m_prev) + 255) & 255);
        else if (r < 80) g = m_prev;
        else             g = $urandom_range(0, 255);
        cyc(0, $urandom_range(0, 29) == 0, 1, g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
